// File: rtl/shift_pipe_if.sv
// Handshake bundle for the pipelined barrel shifter/rotator.
// The master drives operands and accepts results; the slave is the shifter.
interface shift_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit,
// LSB first. Every stage advances together on a single global enable, so a
// stalled output freezes the whole pipe (bubbles included) in place.
module shift_pipe #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    shift_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    logic             adv;
    logic             entry_illegal;
    logic [WIDTH-1:0] entry_data;

    // Illegal modes (11x) enter the pipe with zeroed data and the error flag set
    always_comb begin
        entry_illegal = bus.in_mode[2] & bus.in_mode[1];
        entry_data    = entry_illegal ? '0 : bus.in_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : stg
            localparam int SH = 1 << gi;

            // Stage inputs (from the bus for stage 0, else from the previous stage)
            logic             valid_i;
            logic [WIDTH-1:0] data_i;
            logic [SHW-1:0]   shamt_i;
            logic [2:0]       mode_i;
            logic             carry_i;
            logic             err_i;

            logic             valid_d, valid_q;
            logic [WIDTH-1:0] data_d,  data_q;
            logic [SHW-1:0]   shamt_d, shamt_q;
            logic [2:0]       mode_d,  mode_q;
            logic             carry_d, carry_q;
            logic             err_d,   err_q;

            if (gi == 0) begin : g_src
                assign valid_i = bus.in_valid;
                assign data_i  = entry_data;
                assign shamt_i = bus.in_shamt;
                assign mode_i  = bus.in_mode;
                assign carry_i = 1'b0;
                assign err_i   = entry_illegal;
            end else begin : g_src
                assign valid_i = stg[gi-1].valid_q;
                assign data_i  = stg[gi-1].data_q;
                assign shamt_i = stg[gi-1].shamt_q;
                assign mode_i  = stg[gi-1].mode_q;
                assign carry_i = stg[gi-1].carry_q;
                assign err_i   = stg[gi-1].err_q;
            end

            // Conditional shift by 2^gi; the carry is overwritten only when this stage shifts
            always_comb begin
                valid_d = valid_i;
                data_d  = data_i;
                shamt_d = shamt_i;
                mode_d  = mode_i;
                carry_d = carry_i;
                err_d   = err_i;
                if (shamt_i[gi] && !err_i) begin
                    case (mode_i)
                        MODE_LSL, MODE_ASL: begin
                            data_d  = data_i << SH;
                            carry_d = data_i[WIDTH-SH];
                        end
                        MODE_LSR: begin
                            data_d  = data_i >> SH;
                            carry_d = data_i[SH-1];
                        end
                        MODE_ASR: begin
                            // MSB of the stage input is still the original sign bit
                            data_d  = WIDTH'($signed(data_i) >>> SH);
                            carry_d = data_i[SH-1];
                        end
                        MODE_ROL: begin
                            data_d  = (data_i << SH) | (data_i >> (WIDTH - SH));
                            carry_d = data_d[0];
                        end
                        MODE_ROR: begin
                            data_d  = (data_i >> SH) | (data_i << (WIDTH - SH));
                            carry_d = data_d[WIDTH-1];
                        end
                        default: begin
                            data_d  = data_i;
                            carry_d = carry_i;
                        end
                    endcase
                end
            end

            // Stage register: loads only on the global advance enable
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    shamt_q <= '0;
                    mode_q  <= '0;
                    carry_q <= 1'b0;
                    err_q   <= 1'b0;
                end else if (adv) begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    shamt_q <= shamt_d;
                    mode_q  <= mode_d;
                    carry_q <= carry_d;
                    err_q   <= err_d;
                end
            end
        end
    endgenerate

    // The last stage's shift amount and mode are not needed past the pipe
    logic unused_tail;
    assign unused_tail = ^{stg[SHW-1].shamt_q, stg[SHW-1].mode_q};

    // Advance whenever the output slot is empty or being consumed
    always_comb begin
        adv           = ~stg[SHW-1].valid_q | bus.out_ready;
        bus.in_ready  = adv;
        bus.out_valid = stg[SHW-1].valid_q;
        bus.out_data  = stg[SHW-1].data_q;
        bus.out_carry = stg[SHW-1].carry_q;
        bus.out_err   = stg[SHW-1].err_q;
        bus.out_zero  = (stg[SHW-1].data_q == '0);
    end
endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe at WIDTH=16 and WIDTH=32.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_pipe_if #(.WIDTH(16)) bus16 ();
    shift_pipe_if #(.WIDTH(32)) bus32 ();

    shift_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));
    shift_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(bus32));

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Uniform per-instance views (index 0 = 16-bit, 1 = 32-bit)
    logic        ov[2], ordy[2], ivl[2], irdy[2], oc[2], oz[2], oe[2];
    logic [31:0] od[2], idat[2];
    logic [4:0]  ish[2];
    logic [2:0]  imd[2];

    assign ov[0] = bus16.out_valid;  assign ov[1] = bus32.out_valid;
    assign ordy[0] = bus16.out_ready; assign ordy[1] = bus32.out_ready;
    assign ivl[0] = bus16.in_valid;  assign ivl[1] = bus32.in_valid;
    assign irdy[0] = bus16.in_ready; assign irdy[1] = bus32.in_ready;
    assign oc[0] = bus16.out_carry;  assign oc[1] = bus32.out_carry;
    assign oz[0] = bus16.out_zero;   assign oz[1] = bus32.out_zero;
    assign oe[0] = bus16.out_err;    assign oe[1] = bus32.out_err;
    assign od[0] = {16'h0, bus16.out_data};  assign od[1] = bus32.out_data;
    assign idat[0] = {16'h0, bus16.in_data}; assign idat[1] = bus32.in_data;
    assign ish[0] = {1'b0, bus16.in_shamt};  assign ish[1] = bus32.in_shamt;
    assign imd[0] = bus16.in_mode;   assign imd[1] = bus32.in_mode;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        e;
        int          cy;
        int          st;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: shift/rotate computed bit by bit from the mode definitions
    function automatic void model(input logic [31:0] x, input int w, input int s,
                                  input logic [2:0] m, output logic [31:0] r,
                                  output logic c, output logic e);
        r = '0;
        c = 1'b0;
        e = 1'b0;
        if (m[2] && m[1]) begin
            e = 1'b1;
            return;
        end
        for (int i = 0; i < w; i++) begin
            if (m == 3'd0 || m == 3'd2) begin
                if (i >= s) r[i] = x[i-s];
            end else if (m == 3'd1) begin
                if (i + s < w) r[i] = x[i+s];
            end else if (m == 3'd3) begin
                r[i] = (i + s < w) ? x[i+s] : x[w-1];
            end else if (m == 3'd4) begin
                r[i] = x[(i - s + w) % w];
            end else begin
                r[i] = x[(i + s) % w];
            end
        end
        if (s != 0) begin
            if (m == 3'd0 || m == 3'd2)      c = x[w-s];
            else if (m == 3'd1 || m == 3'd3) c = x[s-1];
            else if (m == 3'd4)              c = r[0];
            else                             c = r[w-1];
        end
    endfunction

    // Compare process: scoreboard, latency, stall stability and in_ready rule
    logic        prev_stall[2];
    logic [31:0] prev_d[2];
    logic        prev_c[2], prev_z[2], prev_e[2];
    int          stalls[2];

    initial begin
        exp_t        t;
        logic [31:0] r;
        logic        c, e;
        int          w, shw;
        stalls[0] = 0; stalls[1] = 0;
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                w   = (i == 0) ? 16 : 32;
                shw = (i == 0) ? 4 : 5;
                if (rst) begin
                    if (i == 0) sb0.delete(); else sb1.delete();
                    prev_stall[i] = 1'b0;
                end else begin
                    chk($sformatf("in_ready_rule_w%0d", w), {31'h0, irdy[i]}, {31'h0, ~ov[i] | ordy[i]});
                    if (prev_stall[i]) begin
                        chk($sformatf("stall_data_w%0d", w), od[i], prev_d[i]);
                        chk($sformatf("stall_carry_w%0d", w), {31'h0, oc[i]}, {31'h0, prev_c[i]});
                        chk($sformatf("stall_zero_w%0d", w), {31'h0, oz[i]}, {31'h0, prev_z[i]});
                        chk($sformatf("stall_err_w%0d", w), {31'h0, oe[i]}, {31'h0, prev_e[i]});
                    end
                    if (ov[i] && ordy[i]) begin
                        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL spurious_result_w%0d: got %h, required no result", w, od[i]);
                        end else begin
                            t = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                            chk($sformatf("data_w%0d", w), od[i], t.d);
                            chk($sformatf("carry_w%0d", w), {31'h0, oc[i]}, {31'h0, t.c});
                            chk($sformatf("err_w%0d", w), {31'h0, oe[i]}, {31'h0, t.e});
                            chk($sformatf("zero_w%0d", w), {31'h0, oz[i]}, {31'h0, (t.d == 32'h0)});
                            chk($sformatf("latency_w%0d", w), cyc - t.cy, shw + stalls[i] - t.st);
                        end
                    end
                    if (ivl[i] && irdy[i]) begin
                        model(idat[i], w, int'(ish[i]), imd[i], r, c, e);
                        t.d = r; t.c = c; t.e = e; t.cy = cyc; t.st = stalls[i];
                        if (i == 0) sb0.push_back(t); else sb1.push_back(t);
                    end
                    prev_stall[i] = ov[i] & ~ordy[i];
                    if (prev_stall[i]) stalls[i]++;
                end
                prev_d[i] = od[i];
                prev_c[i] = oc[i];
                prev_z[i] = oz[i];
                prev_e[i] = oe[i];
            end
        end
    end

    // Present one operation (called at posedge+1); returns after it transfers
    task automatic send(input int i, input logic [31:0] d, input logic [4:0] s, input logic [2:0] m);
        if (i == 0) begin
            bus16.in_valid = 1'b1; bus16.in_data = d[15:0];
            bus16.in_shamt = s[3:0]; bus16.in_mode = m;
        end else begin
            bus32.in_valid = 1'b1; bus32.in_data = d;
            bus32.in_shamt = s; bus32.in_mode = m;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (irdy[i]) begin
                @(posedge clk);
                #1;
                bus16.in_valid = 1'b0;
                bus32.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail_now("send_timeout");
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    // Wait for the next output transfer and compare against literal values
    task automatic expect_out(input int i, input string name, input logic [31:0] d,
                              input logic c, input logic z, input logic e);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ov[i] && ordy[i]) begin
                $display("vector %s: data=%h carry=%0b zero=%0b err=%0b", name, od[i], oc[i], oz[i], oe[i]);
                chk({name, "_data"}, od[i], d);
                chk({name, "_carry"}, {31'h0, oc[i]}, {31'h0, c});
                chk({name, "_zero"}, {31'h0, oz[i]}, {31'h0, z});
                chk({name, "_err"}, {31'h0, oe[i]}, {31'h0, e});
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now({name, "_timeout"});
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 80; k++) begin
            if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) return;
            @(negedge clk);
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_shamt = '0; bus16.in_mode = '0;
        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_shamt = '0; bus32.in_mode = '0;
        bus16.out_ready = 1'b1;
        bus32.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", {31'h0, irdy[i]}, 32'h1);
            chk("rst_out_valid", {31'h0, ov[i]}, 32'h0);
            chk("rst_out_data", od[i], 32'h0);
            chk("rst_out_carry", {31'h0, oc[i]}, 32'h0);
            chk("rst_out_zero", {31'h0, oz[i]}, 32'h1);
            chk("rst_out_err", {31'h0, oe[i]}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Mode sweep on 16'hB00F by 4
        send(0, 32'hB00F, 5'd4, 3'b000); expect_out(0, "lsl_b00f", 32'h00F0, 1'b1, 1'b0, 1'b0);
        send(0, 32'hB00F, 5'd4, 3'b001); expect_out(0, "lsr_b00f", 32'h0B00, 1'b1, 1'b0, 1'b0);
        send(0, 32'hB00F, 5'd4, 3'b010); expect_out(0, "asl_b00f", 32'h00F0, 1'b1, 1'b0, 1'b0);
        send(0, 32'hB00F, 5'd4, 3'b011); expect_out(0, "asr_b00f", 32'hFB00, 1'b1, 1'b0, 1'b0);
        send(0, 32'hB00F, 5'd4, 3'b100); expect_out(0, "rol_b00f", 32'h00FB, 1'b1, 1'b0, 1'b0);
        send(0, 32'hB00F, 5'd4, 3'b101); expect_out(0, "ror_b00f", 32'hFB00, 1'b1, 1'b0, 1'b0);

        // Edge cases
        send(0, 32'h8001, 5'd0, 3'b000);  expect_out(0, "lsl_by0", 32'h8001, 1'b0, 1'b0, 1'b0);
        send(0, 32'h8000, 5'd15, 3'b011); expect_out(0, "asr_by15", 32'hFFFF, 1'b0, 1'b0, 1'b0);
        send(0, 32'h0001, 5'd1, 3'b001);  expect_out(0, "lsr_1_by1", 32'h0000, 1'b1, 1'b1, 1'b0);

        // Illegal mode delivered in order between legal operations
        send(0, 32'h1234, 5'd1, 3'b000);
        send(0, 32'hFFFF, 5'd3, 3'b110);
        send(0, 32'h8001, 5'd1, 3'b001);
        expect_out(0, "legal_before", 32'h2468, 1'b0, 1'b0, 1'b0);
        expect_out(0, "illegal_110", 32'h0000, 1'b0, 1'b1, 1'b1);
        expect_out(0, "legal_after", 32'h4000, 1'b1, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back ops with pseudo-random out_ready
        fork
            begin
                for (int n = 0; n < 8; n++)
                    send(0, 32'($urandom), 5'($urandom_range(0, 15)), 3'($urandom_range(0, 5)));
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    @(posedge clk); #1;
                    bus16.out_ready = 1'($urandom_range(0, 1));
                end
                bus16.out_ready = 1'b1;
            end
        join
        drain(0);

        // Asynchronous reset with three operations in flight
        send(0, 32'h00FF, 5'd2, 3'b000);
        send(0, 32'h0F0F, 5'd3, 3'b101);
        send(0, 32'hF000, 5'd1, 3'b011);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", {31'h0, bus16.out_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'h0, bus16.out_valid}, 32'h0);
        chk("async_rst_in_ready", {31'h0, bus16.in_ready}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus16.out_valid) seen++;
        end
        chk("post_rst_results", seen, 0);
        @(posedge clk); #1;

        // WIDTH=32: literal pins, then random full-throughput stream
        send(1, 32'h8000_0000, 5'd31, 3'b011); expect_out(1, "w32_asr_by31", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(1, 32'h0000_0001, 5'd1, 3'b101);  expect_out(1, "w32_ror_by1", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 40; n++)
            send(1, 32'($urandom), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
        drain(1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter/rotator for the ALU datapath. It supports logical, arithmetic and rotate modes on a WIDTH-bit operand, with one pipeline stage per shift-amount bit. Operands and results move through valid/ready handshakes, and a full pipeline sustains one operation per cycle under backpressure. The block also returns carry-out (last bit shifted out), zero and illegal-mode flags for the ALU flag register.

## Interface
- WIDTH, 16, operand width; must be a power of two and at least 4.
- SHW, $clog2(WIDTH) (derived, not overridable), shift-amount width and pipeline depth.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand, amount and mode are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  3  000 LSL, 001 LSR, 010 ASL (same as LSL), 011 ASR, 100 ROL, 101 ROR, 110/111 illegal.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted/rotated result.
- out_carry  out  1  last bit shifted out (definition below).
- out_zero  out  1  out_data == 0.
- out_err  out  1  the operation used an illegal mode.

## Operation
- Pipeline: SHW register stages. Stage k (k = 0..SHW-1, LSB first) shifts by 2^k when shamt bit k is set, else passes data through.
- Each stage registers: valid, data, remaining shamt bits, mode, carry and err.
- Fill bits by mode:
  - LSL/ASL fill with 0 at the LSB.
  - LSR fills with 0 at the MSB.
  - ASR fills with the original sign bit (in_data[WIDTH-1]) at the MSB.
  - ROL/ROR wrap the shifted-out bits to the opposite end.
- Carry:
  - Starts at 0.
  - A stage whose bit is set overwrites carry. For LSL it takes the bit at index WIDTH-2^k of that stage's input. For LSR/ASR it takes index 2^k-1. For ROL it takes the new result[0]. For ROR it takes the new result[WIDTH-1].
  - A stage whose bit is clear holds carry.
  - Net effect: shamt 0 gives carry 0. Otherwise LSL gives original bit WIDTH-s, and LSR/ASR give original bit s-1.
- Illegal mode: data is forced to 0 at stage 0 entry, err=1 travels with the operation, and carry=0. The operation is still accepted and returned; it is not dropped.
- out_zero is computed combinationally from the final-stage data register.
- Reset clears every stage valid, data, carry and err to 0.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_data = 0, out_carry = 0, out_zero = 1, out_err = 0.
- Transfers:
  - An input transfer happens on a clock edge with in_valid & in_ready.
  - An output transfer happens on a clock edge with out_valid & out_ready.
- Global advance enable: adv = ~out_valid | out_ready. When adv=1, all stages shift forward one position and stage 0 loads the input (valid = in_valid).
- in_ready = adv. It is combinational from out_ready; this is the only combinational path from an output to an input.
- Latency: exactly SHW cycles from input transfer to out_valid with no stall (4 cycles at WIDTH=16). Throughput is 1/cycle.
- Stall (out_valid=1, out_ready=0):
  - All stages hold.
  - out_data, out_carry, out_zero and out_err stay stable.
  - in_ready=0.
- Bubbles are not compressed. Empty stages advance only with adv, so a stall freezes bubbles in place.
- Simultaneous input and output transfer in one cycle is legal and loses no data.
- Asynchronous rst mid-operation discards all in-flight operations. out_valid drops immediately, with no partial result.

## Test plan
- Reset then idle: assert rst mid-stream with 3 ops in flight. Required: out_valid=0 at once, in_ready=1, and no result emerges after release.
- Mode sweep at WIDTH=16, in_data=16'hB00F, shamt=4, out_ready=1, required results after 4 cycles:
  - LSL: 16'h00F0, carry 1.
  - LSR: 16'h0B00, carry 1.
  - ASR: 16'hFB00, carry 1.
  - ROL: 16'h00FB, carry 1.
  - ROR: 16'hFB00, carry 1.
- Edges:
  - shamt=0 on LSL with 16'h8001 -> 16'h8001, carry 0.
  - shamt=15 on ASR with 16'h8000 -> 16'hFFFF, carry 0.
  - LSR of 16'h0001 by 1 -> 16'h0000, carry 1, zero 1.
- Illegal mode 3'b110 with in_data=16'hFFFF -> out_data 0, err 1, zero 1, delivered in order between legal ops.
- Backpressure: stream 8 back-to-back ops while toggling out_ready pseudo-randomly. Required: results exact and in order against a reference model, outputs stable while stalled, and in_ready==~out_valid|out_ready every cycle.
- Parameter run at WIDTH=32 (SHW=5): random ops in all modes with full-throughput streaming. Required: latency 5 and bit-exact match including carry.
